// File: rtl/spike_merge_arbiter.sv
// spike_merge_arbiter
//
// Purpose:
//     Merges the pos/neg spike lines of N upstream neurons onto one shared
//     downstream neuron without losing simultaneous spikes. Each input keeps
//     a saturating pending counter per polarity. A round-robin arbiter then
//     replays the queued spikes one per cycle onto pos_out/neg_out.
//
// Ports:
//     clk       - single clock, all state changes on the rising edge
//     rst       - synchronous active-high reset, drops every queued spike
//     en        - grant enable; low freezes draining, arrivals still counted
//     ovf_clr   - clears the sticky overflow flags
//     pos_req   - [N] positive spike pulse from upstream neuron i
//     neg_req   - [N] negative spike pulse from upstream neuron i
//     pos_out   - registered positive spike to the shared neuron
//     neg_out   - registered negative spike to the shared neuron
//     grant_id  - [IDW] input whose spike is currently on pos_out/neg_out
//     pending   - some counter is nonzero
//     ovf       - [N] sticky flag: input i dropped a spike at saturation

module spike_merge_arbiter #(
    parameter int N     = 4,
    parameter int IDW   = 2,
    parameter int CNT_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           ovf_clr,
    input  logic [N-1:0]   pos_req,
    input  logic [N-1:0]   neg_req,
    output logic           pos_out,
    output logic           neg_out,
    output logic [IDW-1:0] grant_id,
    output logic           pending,
    output logic [N-1:0]   ovf
);

    localparam int SELW = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_pCnt [N];
    logic [CNT_W-1:0] r_nCnt [N];
    logic [IDW-1:0]   r_ptr;
    logic [N-1:0]     r_ovf;
    logic             r_posOut;
    logic             r_negOut;
    logic [IDW-1:0]   r_grantId;

    logic [N-1:0]     w_elig;
    logic             w_grant;
    logic [IDW-1:0]   w_gid;
    logic             w_isPos;
    logic [SELW-1:0]  w_idx;
    logic [N-1:0]     w_pDec;
    logic [N-1:0]     w_nDec;
    logic [N-1:0]     w_drop;

    // Index reached by stepping 'step' places past 'base', wrapping at N.
    function automatic logic [SELW-1:0] f_wrap(input logic [IDW-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        return SELW'(sum % N);
    endfunction

    // An input is eligible whenever either of its counters holds spikes.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N; i++) begin
            w_elig[i] = (r_pCnt[i] != '0) || (r_nCnt[i] != '0);
        end
    end

    assign pending = |w_elig;

    // Round-robin search starting just after the last granted input. The
    // chosen polarity is resolved here too, so positive spikes of the
    // winning input always drain before its negative ones.
    always_comb begin
        w_grant = 1'b0;
        w_gid   = '0;
        w_isPos = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = f_wrap(r_ptr, k);
            if (en && !w_grant && w_elig[w_idx]) begin
                w_grant = 1'b1;
                w_gid   = IDW'(w_idx);
                w_isPos = (r_pCnt[w_idx] != '0);
            end
        end
    end

    // Per-counter decrement and saturation-drop decode. A request arriving in
    // the same cycle as a decrement is absorbed, so it can never be dropped.
    always_comb begin
        w_pDec = '0;
        w_nDec = '0;
        w_drop = '0;
        for (int i = 0; i < N; i++) begin
            w_pDec[i] = w_grant && (w_gid == IDW'(i)) && w_isPos;
            w_nDec[i] = w_grant && (w_gid == IDW'(i)) && !w_isPos;
            w_drop[i] = (pos_req[i] && !w_pDec[i] && (r_pCnt[i] == CNT_MAX)) ||
                        (neg_req[i] && !w_nDec[i] && (r_nCnt[i] == CNT_MAX));
        end
    end

    // Counter update: next = cnt + req - dec, holding at saturation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_pCnt[i] <= '0;
                r_nCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pos_req[i] && !w_pDec[i] && (r_pCnt[i] != CNT_MAX)) begin
                    r_pCnt[i] <= r_pCnt[i] + CNT_W'(1);
                end else if (!pos_req[i] && w_pDec[i]) begin
                    r_pCnt[i] <= r_pCnt[i] - CNT_W'(1);
                end
                if (neg_req[i] && !w_nDec[i] && (r_nCnt[i] != CNT_MAX)) begin
                    r_nCnt[i] <= r_nCnt[i] + CNT_W'(1);
                end else if (!neg_req[i] && w_nDec[i]) begin
                    r_nCnt[i] <= r_nCnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // Pointer, overflow flags and registered outputs. The pointer resets to
    // N-1 so input 0 is first in line. A drop beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= IDW'(N - 1);
            r_ovf     <= '0;
            r_posOut  <= 1'b0;
            r_negOut  <= 1'b0;
            r_grantId <= '0;
        end else begin
            r_ovf    <= w_drop | (r_ovf & ~{N{ovf_clr}});
            r_posOut <= w_grant && w_isPos;
            r_negOut <= w_grant && !w_isPos;
            if (w_grant) begin
                r_ptr     <= w_gid;
                r_grantId <= w_gid;
            end
        end
    end

    assign pos_out  = r_posOut;
    assign neg_out  = r_negOut;
    assign grant_id = r_grantId;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_spike_merge_arbiter.sv
// tb_spike_merge_arbiter
//
// Directed bench for spike_merge_arbiter. Every step pushes the spikes it
// expects (polarity and grant id) onto a queue; each sampled cycle pops one
// entry whenever the DUT shows a spike and compares it.

module tb_spike_merge_arbiter;

    localparam int N     = 4;
    localparam int IDW   = 2;
    localparam int CNT_W = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           ovf_clr = 1'b0;
    logic [N-1:0]   pos_req = '0;
    logic [N-1:0]   neg_req = '0;
    logic           pos_out;
    logic           neg_out;
    logic [IDW-1:0] grant_id;
    logic           pending;
    logic [N-1:0]   ovf;

    typedef struct packed {
        logic           isPos;
        logic [IDW-1:0] id;
    } spike_t;

    spike_t expQ[$];
    int     nChecks = 0;
    int     nFails = 0;
    logic   lastSpike = 1'b0;

    spike_merge_arbiter #(.N(N), .IDW(IDW), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .ovf_clr  (ovf_clr),
        .pos_req  (pos_req),
        .neg_req  (neg_req),
        .pos_out  (pos_out),
        .neg_out  (neg_out),
        .grant_id (grant_id),
        .pending  (pending),
        .ovf      (ovf)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: observed no end of test, expected end before time 50000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] pos, input logic [N-1:0] neg,
                                 input logic enable, input logic clr);
        pos_req = pos;
        neg_req = neg;
        en      = enable;
        ovf_clr = clr;
    endtask

    task automatic expectSpike(input logic isPos, input int id);
        spike_t e;
        e.isPos = isPos;
        e.id    = IDW'(id);
        expQ.push_back(e);
    endtask

    // Advance one edge, sample 1 unit later and score any spike seen.
    task automatic tick();
        spike_t e;
        @(posedge clk);
        #1;
        lastSpike = pos_out | neg_out;
        checkOutput("exclusive", 32'(pos_out & neg_out), 32'(0));
        if (lastSpike) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_spike", 32'(lastSpike), 32'(0));
            end else begin
                e = expQ.pop_front();
                checkOutput("pos_out", 32'(pos_out), 32'(e.isPos));
                checkOutput("neg_out", 32'(neg_out), 32'(!e.isPos));
                checkOutput("grant_id", 32'(grant_id), 32'(e.id));
            end
        end
    endtask

    // Wait (bounded) for the first spike, then require the remaining
    // expected spikes on consecutive cycles.
    task automatic collectSpikes(input int budget);
        int waited;
        waited = 0;
        while (!lastSpike && waited < budget) begin
            tick();
            waited++;
        end
        checkOutput("first_spike", 32'(lastSpike), 32'(1));
        while (expQ.size() > 0 && lastSpike) begin
            tick();
            checkOutput("consecutive", 32'(lastSpike), 32'(1));
        end
        checkOutput("queue_drained", 32'(expQ.size()), 32'(0));
        expQ.delete();
    endtask

    initial begin
        $display("[TB] start");

        // Reset state
        applyStimulus('0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        checkOutput("rst_pos_out", 32'(pos_out), 32'(0));
        checkOutput("rst_neg_out", 32'(neg_out), 32'(0));
        checkOutput("rst_grant_id", 32'(grant_id), 32'(0));
        checkOutput("rst_pending", 32'(pending), 32'(0));
        checkOutput("rst_ovf", 32'(ovf), 32'(0));

        // Single spike on input 2: two-edge latency, one-cycle pulse
        $display("[TB] single spike");
        expectSpike(1'b1, 2);
        applyStimulus(4'b0100, '0, 1'b1, 1'b0);
        tick();
        applyStimulus('0, '0, 1'b1, 1'b0);
        checkOutput("lat_pos_early", 32'(pos_out), 32'(0));
        checkOutput("lat_pending", 32'(pending), 32'(1));
        tick();
        checkOutput("lat_pos_out", 32'(pos_out), 32'(1));
        checkOutput("lat_queue", 32'(expQ.size()), 32'(0));
        tick();
        checkOutput("lat_pos_after", 32'(pos_out), 32'(0));
        checkOutput("lat_pending_after", 32'(pending), 32'(0));

        // Fresh reset, then all four inputs at once: rotation 0,1,2,3
        $display("[TB] all inputs");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) expectSpike(1'b1, i);
        applyStimulus(4'b1111, '0, 1'b1, 1'b0);
        tick();
        applyStimulus('0, '0, 1'b1, 1'b0);
        collectSpikes(4);
        checkOutput("all_ovf", 32'(ovf), 32'(0));

        // Input 1 both polarities twice: pos, pos, neg, neg
        $display("[TB] polarity order");
        expectSpike(1'b1, 1);
        expectSpike(1'b1, 1);
        expectSpike(1'b0, 1);
        expectSpike(1'b0, 1);
        applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0);
        tick();
        tick();
        applyStimulus('0, '0, 1'b1, 1'b0);
        collectSpikes(4);
        tick();
        checkOutput("pol_pending_after", 32'(pending), 32'(0));

        // Saturation with draining frozen
        $display("[TB] saturation");
        applyStimulus(4'b1000, '0, 1'b0, 1'b0);
        repeat (7) tick();
        checkOutput("sat_ovf_before", 32'(ovf), 32'(0));
        repeat (2) tick();
        checkOutput("sat_ovf_set", 32'(ovf), 32'(4'b1000));
        checkOutput("sat_pending", 32'(pending), 32'(1));
        for (int i = 0; i < 7; i++) expectSpike(1'b1, 3);
        applyStimulus('0, '0, 1'b1, 1'b0);
        collectSpikes(4);
        tick();
        checkOutput("sat_pending_after", 32'(pending), 32'(0));
        checkOutput("sat_ovf_sticky", 32'(ovf), 32'(4'b1000));

        // Clear held during refill: clears first, then a drop beats the clear
        applyStimulus(4'b1000, '0, 1'b0, 1'b1);
        repeat (7) tick();
        checkOutput("setwins_cleared", 32'(ovf), 32'(0));
        tick();
        checkOutput("setwins_set", 32'(ovf), 32'(4'b1000));
        for (int i = 0; i < 7; i++) expectSpike(1'b1, 3);
        applyStimulus('0, '0, 1'b1, 1'b0);
        collectSpikes(4);
        applyStimulus('0, '0, 1'b1, 1'b1);
        tick();
        checkOutput("ovf_clr", 32'(ovf), 32'(0));
        applyStimulus('0, '0, 1'b1, 1'b0);

        // Input 0 requesting every cycle while input 2 holds three spikes
        $display("[TB] fairness");
        applyStimulus(4'b0100, '0, 1'b0, 1'b0);
        repeat (3) tick();
        applyStimulus(4'b0001, '0, 1'b0, 1'b0);
        tick();
        expectSpike(1'b1, 0);
        expectSpike(1'b1, 2);
        expectSpike(1'b1, 0);
        expectSpike(1'b1, 2);
        expectSpike(1'b1, 0);
        expectSpike(1'b1, 2);
        expectSpike(1'b1, 0);
        expectSpike(1'b1, 0);
        expectSpike(1'b1, 0);
        applyStimulus(4'b0001, '0, 1'b1, 1'b0);
        repeat (5) tick();
        applyStimulus('0, '0, 1'b1, 1'b0);
        collectSpikes(4);
        tick();
        checkOutput("fair_pending_after", 32'(pending), 32'(0));
        checkOutput("fair_ovf", 32'(ovf), 32'(0));

        // Reset in the middle of draining five queued spikes
        $display("[TB] reset mid-drain");
        applyStimulus(4'b1111, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(4'b0010, '0, 1'b0, 1'b0);
        tick();
        expectSpike(1'b1, 1);
        expectSpike(1'b1, 2);
        applyStimulus('0, '0, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("mid_queue", 32'(expQ.size()), 32'(0));
        rst = 1'b1;
        applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        applyStimulus('0, '0, 1'b1, 1'b0);
        checkOutput("mid_rst_pos", 32'(pos_out), 32'(0));
        checkOutput("mid_rst_neg", 32'(neg_out), 32'(0));
        checkOutput("mid_rst_gid", 32'(grant_id), 32'(0));
        checkOutput("mid_rst_pending", 32'(pending), 32'(0));
        repeat (3) tick();
        checkOutput("mid_idle_pending", 32'(pending), 32'(0));
        for (int i = 0; i < N; i++) expectSpike(1'b1, i);
        applyStimulus(4'b1111, '0, 1'b1, 1'b0);
        tick();
        applyStimulus('0, '0, 1'b1, 1'b0);
        collectSpikes(4);
        tick();
        checkOutput("final_pending", 32'(pending), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
